// File: rtl/seg_pkg.sv
// Shared definitions for the four-digit multiplexed seven-segment display.
package seg_pkg;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex nibble.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // All segments off (active-low).
    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Scan index states: first and last digit of a frame.
    localparam logic [1:0] IDX_FIRST = 2'd0;
    localparam logic [1:0] IDX_LAST  = 2'd3;

    // Per-frame copy of the display inputs.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  blank;
        logic [3:0]  blink_sel;
    } snap_t;

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment glyph, pure table lookup.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Look up the glyph for the selected nibble.
    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg_display.sv
// Four-digit multiplexed hex display with frame snapshot, per-digit
// blanking, decimal points and adjust-mode blinking.
module seg_display
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        adj,
    input  logic [3:0]  blink_sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    idx;
    logic          phase;
    logic          loaded;
    snap_t         snap;

    logic          refresh_wrap;
    logic          frame_wrap;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          dark;

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign frame_wrap   = refresh_wrap && (idx == IDX_LAST);

    // Digit period counter; its wrap steps the scan index (2-bit, wraps 3->0).
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= IDX_FIRST;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Capture the inputs once per frame, plus once right after reset so the
    // first frame does not show the cleared snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap   <= '0;
            loaded <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (!loaded || frame_wrap) begin
                snap <= '{value, dp_in, blank, blink_sel};
            end
        end
    end

    // Blink half-period counter; held visible and at zero outside adjust mode.
    always_ff @(posedge clk) begin
        if (rst || !adj) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Select the nibble for the current digit and decide whether it is dark.
    always_comb begin
        nibble = snap.value[{idx, 2'b00} +: 4];
        dark   = snap.blank[idx] | (adj & snap.blink_sel[idx] & ~phase);
    end

    seg_decoder u_decoder (
        .nibble (nibble),
        .glyph  (glyph)
    );

    // Registered drivers; the snapshot-load cycle after reset stays dark
    // because the snapshot is not valid until that edge.
    always_ff @(posedge clk) begin
        if (rst || !loaded) begin
            an  <= '1;
            seg <= BLANK_SEG;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= dark ? BLANK_SEG : glyph;
            dp  <= dark ? 1'b1 : ~snap.dp_in[idx];
        end
    end

endmodule

// File: doc/seg_display.md
SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz).
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period (2 Hz blink at 100 MHz).
REQ-003 clk  in  1  system clock, 100 MHz; every register updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 value  in  16  four 4-bit hex digits; [15:12] is digit 3 (leftmost), [3:0] is digit 0 (rightmost).
REQ-006 dp_in  in  4  decimal-point request per digit, 1 = lit.
REQ-007 blank  in  4  per-digit blank, 1 = digit dark regardless of value.
REQ-008 adj  in  1  adjust mode, 1 = digits selected by blink_sel blink.
REQ-009 blink_sel  in  4  per-digit blink enable, used only while adj = 1.
REQ-010 an  out  4  anode enables, active-low, one-hot-low while scanning.
REQ-011 seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  out  1  decimal-point cathode, active-low.

Function
REQ-013 refresh_cnt SHALL count 0..REFRESH_DIV-1 and wrap; the wrap cycle SHALL advance idx (2 bits) 0->1->2->3->0.
REQ-014 snap SHALL latch {value, dp_in, blank, blink_sel} only in the cycle where idx wraps 3->0, so a whole frame shows one coherent value (no tearing).
REQ-015 blink_cnt SHALL count 0..BLINK_DIV-1; its wrap SHALL toggle phase; phase=1 means visible.
REQ-016 While adj=0, phase SHALL be forced to 1 and blink_cnt held at 0, so blinking always starts visible.
REQ-017 an, seg, dp SHALL be registered from idx, snap and phase, so an changes exactly one clock after idx changes.
REQ-018 For the digit at idx, an SHALL drive bit idx low and all other bits high.
REQ-019 seg SHALL be the hex glyph of the selected nibble (0-9, A, b, C, d, E, F), taken from the shared glyph table.
REQ-020 seg SHALL be 7'h7F and dp SHALL be 1 when snap.blank[idx]=1, or when adj=1 and snap.blink_sel[idx]=1 and phase=0; an still scans in both cases.
REQ-021 dp SHALL be ~snap.dp_in[idx] when the digit is not dark.
REQ-022 Changes to value mid-frame SHALL have no effect until the next 3->0 wrap; a value change in the wrap cycle itself SHALL be captured.
REQ-023 If the refresh and blink wraps occur in the same cycle, both SHALL take effect independently.
REQ-024 Parameter values below 2 are unsupported; counter width SHALL be $clog2 of the divider.

Reset
REQ-025 While rst=1: an=4'b1111, seg=7'h7F, dp=1, refresh_cnt=0, blink_cnt=0, idx=0, snap=0, phase=1.
REQ-026 On the first cycle after rst falls, snap SHALL load the current inputs, so the first frame is not all zeros.
REQ-027 rst asserted mid-frame SHALL return the block to the REQ-025 state on the next edge; no partial digit period persists.

Structure
REQ-028 Package seg_pkg SHALL hold the 16-entry active-low glyph table, the BLANK_SEG constant (7'h7F) and the snapshot struct typedef.
REQ-029 Sub-module seg_decoder (4-bit nibble -> 7-bit active-low glyph, combinational, table lookup) SHALL be instantiated once.
REQ-030 All counters and the FSM (idx) SHALL reside in seg_display; no clock dividers or gated clocks are permitted.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-031 Reset then value=16'h1234, blank=0: an sequence 1110,1101,1011,0111 repeating every 16 cycles; seg=4,3,2,1 glyphs (7'h19,7'h30,7'h24,7'h79).
REQ-032 Change value to 16'hABCD while idx=1: remaining digits of the frame still show 2,1; next frame shows D,C,b,A.
REQ-033 blank=4'b1000, dp_in=4'b0100: digit 3 gives seg=7'h7F and dp=1; digit 2 gives dp=0.
REQ-034 adj=1, blink_sel=4'b0001: digit 0 is visible for 16 cycles, then dark for 16 cycles; the other digits are never dark. Dropping adj makes digit 0 visible the next cycle.
REQ-035 Assert rst for 1 cycle mid-digit: the next cycle gives an=1111, seg=7'h7F; scanning restarts at digit 0 with the current value.
